// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder between the UART RX strobe and the watch core.
// Buffers RX bytes in a small FIFO, pulses virtual buttons and optionally echoes each byte.
module uart_cmd_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter bit ECHO_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       btn_u,
    output logic       btn_d,
    output logic       btn_l,
    output logic       btn_r,
    output logic [1:0] sw_uart,
    output logic       clr,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DECODE, ECHO} state_t;

    state_t         state, state_n;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty, push, pop;
    logic [7:0]     cmd_reg, cmd_n, echo_reg, echo_n, tx_data_n;
    logic           tx_start_n, btn_u_n, btn_d_n, btn_l_n, btn_r_n, clr_n;
    logic [1:0]     sw_n;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty;
    // A full FIFO still accepts a byte in the same cycle the head is popped.
    assign push  = rx_done && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rx_done && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmd_reg  <= '0;
            echo_reg <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            btn_u    <= 1'b0;
            btn_d    <= 1'b0;
            btn_l    <= 1'b0;
            btn_r    <= 1'b0;
            clr      <= 1'b0;
            sw_uart  <= 2'b00;
        end else begin
            state    <= state_n;
            cmd_reg  <= cmd_n;
            echo_reg <= echo_n;
            tx_start <= tx_start_n;
            tx_data  <= tx_data_n;
            btn_u    <= btn_u_n;
            btn_d    <= btn_d_n;
            btn_l    <= btn_l_n;
            btn_r    <= btn_r_n;
            clr      <= clr_n;
            sw_uart  <= sw_n;
        end
    end

    always_comb begin
        state_n    = state;
        cmd_n      = cmd_reg;
        echo_n     = echo_reg;
        tx_data_n  = tx_data;
        sw_n       = sw_uart;
        tx_start_n = 1'b0;
        btn_u_n    = 1'b0;
        btn_d_n    = 1'b0;
        btn_l_n    = 1'b0;
        btn_r_n    = 1'b0;
        clr_n      = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    cmd_n   = mem[rd_ptr];
                    state_n = DECODE;
                end
            end
            DECODE: begin
                echo_n = cmd_reg;
                // Setting bit 5 folds upper case onto lower case; only letter pairs alias.
                case (cmd_reg | 8'h20)
                    8'h75:   btn_u_n = 1'b1;
                    8'h64:   btn_d_n = 1'b1;
                    8'h6C:   btn_l_n = 1'b1;
                    8'h72:   btn_r_n = 1'b1;
                    8'h6D:   sw_n[0] = ~sw_uart[0];
                    8'h73:   sw_n[1] = ~sw_uart[1];
                    8'h63:   clr_n   = 1'b1;
                    default: echo_n  = 8'h3F;
                endcase
                state_n = ECHO_EN ? ECHO : IDLE;
            end
            ECHO: begin
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = echo_reg;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: echo-enabled instance plus an echo-less instance.
module tb_uart_cmd_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0, rx0_data = '0;
    logic       rx_done = 1'b0, rx0_done = 1'b0;
    logic       tx_busy = 1'b0, tx0_busy = 1'b0;
    logic       tx_start, btn_u, btn_d, btn_l, btn_r, clr, overflow;
    logic [7:0] tx_data;
    logic [1:0] sw_uart;
    logic       tx0_start, b0_u, b0_d, b0_l, b0_r, clr0, ovf0;
    logic [7:0] tx0_data;
    logic [1:0] sw0;

    int checks = 0, failures = 0;
    int n_u = 0, n_d = 0, n_l = 0, n_r = 0, n_c = 0, n_tx = 0, n_tx0 = 0, n_ovl = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.FIFO_DEPTH(4), .ECHO_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .btn_u(btn_u), .btn_d(btn_d),
        .btn_l(btn_l), .btn_r(btn_r), .sw_uart(sw_uart), .clr(clr), .overflow(overflow));

    uart_cmd_decoder #(.FIFO_DEPTH(4), .ECHO_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx0_data), .rx_done(rx0_done), .tx_busy(tx0_busy),
        .tx_start(tx0_start), .tx_data(tx0_data), .btn_u(b0_u), .btn_d(b0_d),
        .btn_l(b0_l), .btn_r(b0_r), .sw_uart(sw0), .clr(clr0), .overflow(ovf0));

    always @(posedge clk) begin
        if (btn_u) n_u <= n_u + 1;
        if (btn_d) n_d <= n_d + 1;
        if (btn_l) n_l <= n_l + 1;
        if (btn_r) n_r <= n_r + 1;
        if (clr)   n_c <= n_c + 1;
        if (tx_start)  n_tx  <= n_tx + 1;
        if (tx0_start) n_tx0 <= n_tx0 + 1;
        if (int'(btn_u) + int'(btn_d) + int'(btn_l) + int'(btn_r) + int'(clr) > 1) n_ovl <= n_ovl + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Advance until tx_start is seen (sampled #1 after an edge), bounded.
    task automatic wait_tx(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (tx_start) ok = 1'b1;
            else tick();
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
    endtask

    logic [7:0] exp_echo [5];
    bit ok;
    int su, sd, sl, sr, sc, stx;

    initial begin
        exp_echo[0] = 8'h55; exp_echo[1] = 8'h44; exp_echo[2] = 8'h4C;
        exp_echo[3] = 8'h52; exp_echo[4] = 8'h4D;
        tick(2);
        check("rst_outs", {tx_start, btn_u, btn_d, btn_l, btn_r, clr, overflow}, 0);
        check("rst_sw_txd", {sw_uart, tx_data}, 0);
        rst = 1'b1;
        tick(2);

        // 'U': pulse at N+3, echo at N+4
        send(8'h55);
        check("u_n1", {btn_u, tx_start}, 0);
        tick();
        check("u_n2", {btn_u, tx_start}, 0);
        tick();
        check("u_n3_btn", {btn_u, btn_d, btn_l, btn_r, clr, tx_start}, 6'b100000);
        tick();
        check("u_n4_tx", {btn_u, tx_start}, 2'b01);
        check("u_n4_txd", tx_data, 8'h55);
        tick();
        check("u_n5", {btn_u, tx_start}, 0);
        tick(3);

        // 'm' then 'M' toggle sw_uart[0]
        su = n_u; sd = n_d; sl = n_l; sr = n_r; sc = n_c;
        send(8'h6D);
        tick(9);
        check("m_sw", sw_uart, 2'b01);
        send(8'h4D);
        tick(9);
        check("M_sw", sw_uart, 2'b00);
        check("m_nobtn", (n_u-su)+(n_d-sd)+(n_l-sl)+(n_r-sr)+(n_c-sc), 0);

        // 'S' toggles sw_uart[1]
        send(8'h53);
        tick(6);
        check("S_sw", sw_uart, 2'b10);

        // unknown 'x' echoes '?'
        su = n_u; sc = n_c;
        send(8'h78);
        wait_tx("x_tx", ok);
        if (ok) check("x_txd", tx_data, 8'h3F);
        tick(3);
        check("x_noeff", {sw_uart, 8'(n_u-su), 8'(n_c-sc)}, {2'b10, 16'h0});

        // overflow: busy TX, 6 back-to-back bytes, last one dropped
        tx_busy = 1'b1;
        su = n_u; sd = n_d; sl = n_l; sr = n_r; sc = n_c;
        send(8'h55); send(8'h44); send(8'h4C); send(8'h52); send(8'h4D); send(8'h43);
        tick(4);
        check("ovf_flag", overflow, 1);
        check("ovf_first_only", {8'(n_u-su), 8'(n_d-sd)}, 16'h0100);
        tx_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_tx($sformatf("ovf_tx%0d", k), ok);
            if (ok) check($sformatf("ovf_txd%0d", k), tx_data, {24'h0, exp_echo[k]});
            tick();
        end
        stx = n_tx;
        tick(20);
        check("ovf_no6th", n_tx - stx, 0);
        check("ovf_pulses", {8'(n_u-su), 8'(n_d-sd), 8'(n_l-sl), 8'(n_r-sr)}, 32'h01010101);
        check("ovf_noclr", n_c - sc, 0);
        check("ovf_sw", sw_uart, 2'b11);
        check("ovf_sticky", overflow, 1);

        // reset during ECHO cancels the echo
        tx_busy = 1'b1;
        sc = n_c;
        send(8'h63);
        tick(5);
        check("c_clr_once", n_c - sc, 1);
        stx = n_tx;
        rst = 1'b0;
        #1;
        check("rst_mid_outs", {tx_start, btn_u, btn_d, btn_l, btn_r, clr, overflow}, 0);
        check("rst_mid_sw_txd", {sw_uart, tx_data}, 0);
        tick();
        rst = 1'b1;
        tx_busy = 1'b0;
        tick(10);
        check("rst_no_tx", n_tx - stx, 0);

        // echo-less instance: 'r','l' back-to-back
        rx0_data = 8'h72; rx0_done = 1'b1;
        tick();
        rx0_data = 8'h6C;
        tick();
        rx0_done = 1'b0;
        check("e0_n2", {b0_r, b0_l}, 0);
        tick();
        check("e0_n3_r", {b0_r, b0_l, b0_u, b0_d, clr0}, 5'b10000);
        tick();
        check("e0_n4", {b0_r, b0_l}, 0);
        tick();
        check("e0_n5_l", {b0_r, b0_l}, 2'b01);
        tick(5);
        check("e0_no_tx", n_tx0, 0);
        check("no_overlap", n_ovl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
